// File: rtl/regfile8_onehot.sv
// 8-entry x WIDTH register file with one one-hot write port and two
// registered read ports. The entry at ZERO_REG always reads as zero.
// A write select with more than one bit set is dropped, and it sets a sticky
// error flag.
// Optional feature: define REGFILE_BYPASS_EN to forward an accepted write to
// a read of the same index in the same cycle (write-first).
module regfile8_onehot #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid,
  output logic             err_multi
);

  localparam logic [2:0] ZERO_IDX = 3'(ZERO_REG);

  // True when exactly one bit of the select is set.
  function automatic logic is_onehot(input logic [7:0] sel);
    return (sel != 8'h00) && ((sel & (sel - 8'h01)) == 8'h00);
  endfunction

  // True when two or more bits of the select are set.
  function automatic logic is_multihot(input logic [7:0] sel);
    return (sel != 8'h00) && ((sel & (sel - 8'h01)) != 8'h00);
  endfunction

  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_multi_q, err_multi_d;
  logic             wr_multi_s, wr_accept_s;
  logic [WIDTH-1:0] val_a_s, val_b_s;
`ifdef REGFILE_BYPASS_EN
  logic             fwd_a_s, fwd_b_s;
`endif

  // Classify the write select: an accepted write is one-hot and does not target the zero entry.
  always_comb begin
    wr_multi_s  = is_multihot(wr_sel);
    wr_accept_s = is_onehot(wr_sel) && !wr_sel[ZERO_IDX];
  end

  // Next state of each entry; the zero entry is held at 0 permanently.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (i == ZERO_REG) begin
        mem_d[i] = '0;
      end else if (wr_accept_s && wr_sel[i]) begin
        mem_d[i] = wr_data;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward only accepted writes, and decide separately for each port.
  always_comb begin
    fwd_a_s = wr_accept_s && wr_sel[rd_addr_a];
    fwd_b_s = wr_accept_s && wr_sel[rd_addr_b];
  end
`endif

  // Resolve the value that each read port returns this cycle.
  always_comb begin
    if (rd_addr_a == ZERO_IDX) begin
      val_a_s = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (fwd_a_s) begin
      val_a_s = wr_data;
`endif
    end else begin
      val_a_s = mem_q[rd_addr_a];
    end
    if (rd_addr_b == ZERO_IDX) begin
      val_b_s = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (fwd_b_s) begin
      val_b_s = wr_data;
`endif
    end else begin
      val_b_s = mem_q[rd_addr_b];
    end
  end

  // Next state of the read outputs (they hold when idle) and of the sticky error.
  always_comb begin
    rd_valid_d = rd_req;
    if (rd_req) begin
      rd_data_a_d = val_a_s;
      rd_data_b_d = val_b_s;
    end else begin
      rd_data_a_d = rd_data_a_q;
      rd_data_b_d = rd_data_b_q;
    end
    err_multi_d = err_multi_q | wr_multi_s;
  end

  // State update; a synchronous reset overrides any write or read in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_valid_q  <= rd_valid_d;
      err_multi_q <= err_multi_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;
  assign err_multi = err_multi_q;

endmodule

// File: tb/tb_regfile8_onehot.sv
// Scoreboard bench for regfile8_onehot: the stimulus side computes the
// expected outputs from an array model and queues them. A monitor that runs
// just after each rising edge pops one entry and compares it with the DUT.
module tb_regfile8_onehot;

  localparam int ZR = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  wr_sel;
  logic [63:0] wr_data;
  logic        rd_req;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [63:0] rd_data_a, rd_data_b;
  logic        rd_valid, err_multi;

  typedef struct packed {
    logic        v;
    logic [63:0] a;
    logic [63:0] b;
    logic        e;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors    = 0;
  int          miscompares = 0;

  logic [63:0] m_mem [8];
  logic [63:0] m_rda, m_rdb;
  logic        m_valid, m_err;

  regfile8_onehot #(.WIDTH(64), .ZERO_REG(ZR)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_valid  (rd_valid),
    .err_multi (err_multi)
  );

  always #5 clk = ~clk;

  // Value a read of index k returns, using the entries as held before the edge.
  function automatic logic [63:0] model_value(input int k, input int ones, input int widx,
                                              input logic [63:0] data);
    if (k == ZR) return 64'h0;
`ifdef REGFILE_BYPASS_EN
    if (ones == 1 && widx == k) return data;
`endif
    return m_mem[k];
  endfunction

  // Apply one cycle of stimulus, advance the model and queue the expected outputs.
  task automatic step(input logic rst, input logic [7:0] sel, input logic [63:0] data,
                      input logic req, input logic [2:0] a, input logic [2:0] b);
    int ones;
    int widx;
    reset = rst; wr_sel = sel; wr_data = data; rd_req = req;
    rd_addr_a = a; rd_addr_b = b;
    ones = $countones(sel);
    widx = -1;
    for (int i = 0; i < 8; i++) if (sel[i]) widx = i;
    if (!rst) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 64'h0;
      m_rda = 64'h0; m_rdb = 64'h0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      if (req) begin
        m_rda = model_value(int'(a), ones, widx, data);
        m_rdb = model_value(int'(b), ones, widx, data);
      end
      m_valid = req;
      if (ones >= 2) m_err = 1'b1;
      else if (ones == 1 && widx != ZR) m_mem[widx] = data;
    end
    exp_q.push_back('{v: m_valid, a: m_rda, b: m_rdb, e: m_err});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: after every rising edge, compare the DUT outputs with the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rd_valid !== e.v) begin
        miscompares++;
        $display("FAIL rd_valid @%0t: got %b expected %b", $time, rd_valid, e.v);
      end
      if (rd_data_a !== e.a) begin
        miscompares++;
        $display("FAIL rd_data_a @%0t: got %h expected %h", $time, rd_data_a, e.a);
      end
      if (rd_data_b !== e.b) begin
        miscompares++;
        $display("FAIL rd_data_b @%0t: got %h expected %h", $time, rd_data_b, e.b);
      end
      if (err_multi !== e.e) begin
        miscompares++;
        $display("FAIL err_multi @%0t: got %b expected %b", $time, err_multi, e.e);
      end
    end
  end

  initial begin
    logic [7:0] sel;
    int         r;
    // 1. reset for two cycles, then read indices 0 and 6
    step(1'b0, 8'h00, 64'h0, 1'b0, 3'd0, 3'd0);
    step(1'b0, 8'h00, 64'h0, 1'b0, 3'd0, 3'd0);
    step(1'b1, 8'h00, 64'h0, 1'b1, 3'd0, 3'd6);
    step(1'b1, 8'h00, 64'h0, 1'b0, 3'd0, 3'd0);
    // 2. write entry 3, then read it back
    step(1'b1, 8'b0000_1000, 64'hDEAD_BEEF, 1'b0, 3'd0, 3'd0);
    step(1'b1, 8'h00, 64'h0, 1'b1, 3'd3, 3'd3);
    // 3. a write to the zero entry is dropped
    step(1'b1, 8'b1000_0000, 64'h1234, 1'b0, 3'd0, 3'd0);
    step(1'b1, 8'h00, 64'h0, 1'b1, 3'd7, 3'd7);
    // 4. a multi-hot write is rejected and the error stays set
    step(1'b1, 8'b0000_0011, 64'hFF, 1'b0, 3'd0, 3'd0);
    step(1'b1, 8'h00, 64'h0, 1'b1, 3'd0, 3'd1);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h00, 64'h0, 1'b0, 3'd0, 3'd0);
    step(1'b0, 8'h00, 64'h0, 1'b0, 3'd0, 3'd0);
    step(1'b1, 8'h00, 64'h0, 1'b0, 3'd0, 3'd0);
    // 5. a write and a read of the same index in the same cycle
    step(1'b1, 8'b0000_0100, 64'h11, 1'b0, 3'd0, 3'd0);
    step(1'b1, 8'b0000_0100, 64'hA5, 1'b1, 3'd2, 3'd2);
    step(1'b1, 8'h00, 64'h0, 1'b1, 3'd2, 3'd2);
    // 6. reset coinciding with a read and a write
    step(1'b1, 8'b0000_0010, 64'h77, 1'b1, 3'd1, 3'd2);
    step(1'b0, 8'b0000_0100, 64'h99, 1'b1, 3'd2, 3'd2);
    step(1'b1, 8'h00, 64'h0, 1'b1, 3'd2, 3'd1);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      sel = 8'h00;
      else if (r < 8) sel = 8'h01 << $urandom_range(0, 7);
      else            sel = 8'($urandom);
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, sel, {$urandom, $urandom},
           1'($urandom), 3'($urandom), 3'($urandom));
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
